// File: rtl/tmv_fault_monitor_if.sv
// Signal bundle between the TMR voter bank environment and the fault monitor.
// The master drives the channel words and controls. The slave returns enables, flags and statistics.
interface tmv_fault_monitor_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
);
  logic             sample;
  logic             clr_fault;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] a2;
  logic [WIDTH-1:0] a3;
  logic [WIDTH-1:0] y;
  logic             en1;
  logic             en2;
  logic             en3;
  logic [2:0]       fail;
  logic             err;
  logic             dual_fail;
  logic [CNT_W-1:0] mis_cnt;

  modport master (
    output sample, clr_fault, a1, a2, a3, y,
    input  en1, en2, en3, fail, err, dual_fail, mis_cnt
  );

  modport slave (
    input  sample, clr_fault, a1, a2, a3, y,
    output en1, en2, en3, fail, err, dual_fail, mis_cnt
  );
endinterface

// File: rtl/tmv_fault_monitor.sv
// Fault monitor for a bank of TMR voters: tracks consecutive per-channel miscompares against the
// active-low voted word and retires a persistently faulty channel by dropping its registered enable.
module tmv_fault_monitor #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 8
) (
  input logic                clk,
  input logic                rst,
  tmv_fault_monitor_if.slave bus
);

  localparam int unsigned C_W = 4;
  localparam logic [C_W-1:0] THR = C_W'(THRESH);

  typedef enum logic [1:0] {
    ALL_ON    = 2'd0,
    ONE_OFF   = 2'd1,
    DUAL_FAIL = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [2:0]              en_q, en_d;
  logic [2:0]              fail_q, fail_d;
  logic                    err_q, err_d;
  logic                    dual_q, dual_d;
  logic [CNT_W-1:0]        mis_q, mis_d;
  logic [2:0][C_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]        maj_c;
  logic [2:0]              mc_c;
  logic [2:0]              hit_c;
  logic [2:0]              low_c;

  // Voted majority is the inverse of y; a retired channel can never miscompare.
  always_comb begin
    maj_c   = ~bus.y;
    mc_c[0] = en_q[0] & (|(bus.a1 ^ maj_c));
    mc_c[1] = en_q[1] & (|(bus.a2 ^ maj_c));
    mc_c[2] = en_q[2] & (|(bus.a3 ^ maj_c));
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    fail_d  = fail_q;
    err_d   = 1'b0;
    dual_d  = dual_q;
    mis_d   = mis_q;
    cnt_d   = cnt_q;
    hit_c   = 3'b000;
    low_c   = 3'b000;

    if (bus.clr_fault) begin
      state_d = ALL_ON;
      en_d    = 3'b111;
      fail_d  = 3'b000;
      dual_d  = 1'b0;
      cnt_d   = '0;
    end else if (bus.sample) begin
      err_d = |mc_c;
      if ((|mc_c) && (mis_q != {CNT_W{1'b1}})) begin
        mis_d = CNT_W'(mis_q + CNT_W'(1));
      end

      // Consecutive-miscompare counters saturate at the threshold.
      for (int k = 0; k < 3; k++) begin
        if (mc_c[k]) begin
          cnt_d[k] = (cnt_q[k] >= THR) ? THR : C_W'(cnt_q[k] + C_W'(1));
        end else begin
          cnt_d[k] = '0;
        end
        hit_c[k] = mc_c[k] && (cnt_d[k] == THR);
      end

      unique case (state_q)
        ALL_ON: begin
          if (|hit_c) begin
            // Isolate the lowest-index channel that reached the threshold.
            low_c   = hit_c & 3'(~hit_c + 3'd1);
            en_d    = en_q & ~low_c;
            fail_d  = fail_q | low_c;
            state_d = ONE_OFF;
            for (int k = 0; k < 3; k++) begin
              if (low_c[k]) begin
                cnt_d[k] = '0;
              end
            end
            if (|(hit_c & ~low_c)) begin
              dual_d = 1'b1;
            end
          end
        end
        ONE_OFF: begin
          // With two channels left the voter cannot tell which one is wrong.
          if (|mc_c) begin
            dual_d  = 1'b1;
            state_d = DUAL_FAIL;
          end
        end
        DUAL_FAIL: begin
          state_d = DUAL_FAIL;
        end
        default: begin
          state_d = ALL_ON;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ALL_ON;
      en_q    <= 3'b111;
      fail_q  <= 3'b000;
      err_q   <= 1'b0;
      dual_q  <= 1'b0;
      mis_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      dual_q  <= dual_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.en1       = en_q[0];
  assign bus.en2       = en_q[1];
  assign bus.en3       = en_q[2];
  assign bus.fail      = fail_q;
  assign bus.err       = err_q;
  assign bus.dual_fail = dual_q;
  assign bus.mis_cnt   = mis_q;

endmodule

// File: tb/tb_tmv_fault_monitor.sv
// Directed bench for tmv_fault_monitor (WIDTH=2, THRESH=3, CNT_W=8) with hand-computed expectations.
module tb_tmv_fault_monitor;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   exp_mis;

  tmv_fault_monitor_if #(.WIDTH(2), .CNT_W(8)) bus ();

  tmv_fault_monitor #(.WIDTH(2), .THRESH(3), .CNT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [2:0] en_v;
  assign en_v = {bus.en3, bus.en2, bus.en1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic c, input logic [1:0] v1, input logic [1:0] v2,
                       input logic [1:0] v3, input logic [1:0] vy);
    bus.sample = s; bus.clr_fault = c; bus.a1 = v1; bus.a2 = v2; bus.a3 = v3; bus.y = vy;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11);
    step();
    bus.clr_fault = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (en_v !== 3'b111) begin errors++; $display("FAIL reset_en got=%b exp=111", en_v); end
    checks++; if (bus.fail !== 3'b000) begin errors++; $display("FAIL reset_fail got=%b exp=000", bus.fail); end
    checks++; if (bus.err !== 1'b0 || bus.dual_fail !== 1'b0) begin errors++;
      $display("FAIL reset_flags got err=%b dual=%b exp 0 0", bus.err, bus.dual_fail); end
    checks++; if (bus.mis_cnt !== 8'd0) begin errors++; $display("FAIL reset_mis got=%0d exp=0", bus.mis_cnt); end
    exp_mis = 0;
  endtask

  task automatic test_clean();
    drive(1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL clean_err[%0d] got=%b exp=0", i, bus.err); end
    end
    checks++; if (en_v !== 3'b111) begin errors++; $display("FAIL clean_en got=%b exp=111", en_v); end
    checks++; if (bus.mis_cnt !== 8'd0) begin errors++; $display("FAIL clean_mis got=%0d exp=0", bus.mis_cnt); end
  endtask

  task automatic test_retire();
    drive(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      exp_mis++;
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL retire_err[%0d] got=%b exp=1", i, bus.err); end
      if (i < 2) begin
        checks++; if (en_v !== 3'b111) begin errors++; $display("FAIL retire_early_en[%0d] got=%b exp=111", i, en_v); end
      end
    end
    checks++; if (en_v !== 3'b110) begin errors++; $display("FAIL retire_en got=%b exp=110", en_v); end
    checks++; if (bus.fail !== 3'b001) begin errors++; $display("FAIL retire_fail got=%b exp=001", bus.fail); end
    checks++; if (bus.dual_fail !== 1'b0) begin errors++; $display("FAIL retire_dual got=%b exp=0", bus.dual_fail); end
    checks++; if (bus.mis_cnt !== 8'(exp_mis)) begin errors++; $display("FAIL retire_mis got=%0d exp=%0d", bus.mis_cnt, exp_mis); end
    bus.sample = 1'b0;
    step();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL retire_err_drop got=%b exp=0", bus.err); end
    do_clear();
  endtask

  task automatic test_consecutive();
    logic [4:0] pat;
    pat = 5'b11011;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, pat[i] ? 2'b01 : 2'b00, 2'b00, 2'b00, 2'b11);
      step();
      if (pat[i]) exp_mis++;
      checks++; if (bus.err !== pat[i]) begin errors++; $display("FAIL consec_err[%0d] got=%b exp=%b", i, bus.err, pat[i]); end
    end
    checks++; if (en_v !== 3'b111) begin errors++; $display("FAIL consec_en got=%b exp=111", en_v); end
    bus.a1 = 2'b01;
    step();
    exp_mis++;
    checks++; if (en_v !== 3'b110) begin errors++; $display("FAIL consec_third_en got=%b exp=110", en_v); end
    checks++; if (bus.mis_cnt !== 8'(exp_mis)) begin errors++; $display("FAIL consec_mis got=%0d exp=%0d", bus.mis_cnt, exp_mis); end
    do_clear();
  endtask

  task automatic test_dual_retire();
    drive(1'b1, 1'b0, 2'b01, 2'b10, 2'b00, 2'b11);
    step(); step(); step();
    exp_mis += 3;
    checks++; if (en_v !== 3'b110) begin errors++; $display("FAIL dual_en got=%b exp=110", en_v); end
    checks++; if (bus.fail !== 3'b001) begin errors++; $display("FAIL dual_fail_vec got=%b exp=001", bus.fail); end
    checks++; if (bus.dual_fail !== 1'b1) begin errors++; $display("FAIL dual_flag got=%b exp=1", bus.dual_fail); end
    step();
    exp_mis++;
    checks++; if (en_v !== 3'b110 || bus.err !== 1'b1) begin errors++;
      $display("FAIL dual_frozen got en=%b err=%b exp 110 1", en_v, bus.err); end
    checks++; if (bus.mis_cnt !== 8'(exp_mis)) begin errors++; $display("FAIL dual_mis got=%0d exp=%0d", bus.mis_cnt, exp_mis); end
    do_clear();
  endtask

  task automatic test_one_off();
    drive(1'b1, 1'b0, 2'b01, 2'b00, 2'b00, 2'b11);
    step(); step(); step();
    exp_mis += 3;
    step();
    checks++; if (bus.err !== 1'b0 || bus.dual_fail !== 1'b0) begin errors++;
      $display("FAIL oneoff_retired_quiet got err=%b dual=%b exp 0 0", bus.err, bus.dual_fail); end
    drive(1'b0, 1'b0, 2'b00, 2'b01, 2'b00, 2'b11);
    step();
    checks++; if (bus.err !== 1'b0 || bus.mis_cnt !== 8'(exp_mis)) begin errors++;
      $display("FAIL oneoff_hold got err=%b mis=%0d exp 0 %0d", bus.err, bus.mis_cnt, exp_mis); end
    bus.sample = 1'b1;
    step();
    exp_mis++;
    checks++; if (bus.dual_fail !== 1'b1 || bus.err !== 1'b1) begin errors++;
      $display("FAIL oneoff_dual got dual=%b err=%b exp 1 1", bus.dual_fail, bus.err); end
    checks++; if (en_v !== 3'b110 || bus.fail !== 3'b001) begin errors++;
      $display("FAIL oneoff_en got en=%b fail=%b exp 110 001", en_v, bus.fail); end
    drive(1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 2'b11);
    step();
    bus.clr_fault = 1'b0; bus.sample = 1'b0;
    checks++; if (en_v !== 3'b111 || bus.fail !== 3'b000) begin errors++;
      $display("FAIL clr_en got en=%b fail=%b exp 111 000", en_v, bus.fail); end
    checks++; if (bus.dual_fail !== 1'b0 || bus.err !== 1'b0) begin errors++;
      $display("FAIL clr_flags got dual=%b err=%b exp 0 0", bus.dual_fail, bus.err); end
    checks++; if (bus.mis_cnt !== 8'(exp_mis)) begin errors++; $display("FAIL clr_mis got=%0d exp=%0d", bus.mis_cnt, exp_mis); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b11);
    step(); step(); step(); step();
    checks++; if (bus.dual_fail !== 1'b1 || en_v !== 3'b110) begin errors++;
      $display("FAIL pre_rst got dual=%b en=%b exp 1 110", bus.dual_fail, en_v); end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (en_v !== 3'b111 || bus.fail !== 3'b000 || bus.dual_fail !== 1'b0 || bus.err !== 1'b0 || bus.mis_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_rst got en=%b fail=%b dual=%b err=%b mis=%0d exp 111 000 0 0 0",
               en_v, bus.fail, bus.dual_fail, bus.err, bus.mis_cnt);
    end
    bus.sample = 1'b0;
    step();
    rst = 1'b0;
    exp_mis = 0;
  endtask

  task automatic test_saturation();
    drive(1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b11);
    for (int i = 0; i < 255; i++) step();
    checks++; if (bus.mis_cnt !== 8'd255) begin errors++; $display("FAIL sat_reach got=%0d exp=255", bus.mis_cnt); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (bus.mis_cnt !== 8'd255 || bus.err !== 1'b1) begin errors++;
      $display("FAIL sat_hold got mis=%0d err=%b exp 255 1", bus.mis_cnt, bus.err); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp_mis = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    test_reset();
    test_clean();
    test_retire();
    test_consecutive();
    test_dual_retire();
    test_one_off();
    test_async_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
